usb_uart_msg_mux: RTL and testbench

- Parametrised transmit-side source for the USB CDC-ACM UART byte streams.
- Merges two byte sources onto the single uart_in valid/ready stream of the USB UART core:
  - a fixed message, MSG_LEN bytes long, sent every PERIOD cycles;
  - an echo path that buffers received uart_out bytes in a FIFO and loops them back.
- Sits between the usb_uart instance and top-level board glue (LED/status).

---
 rtl/usb_uart_pkg.sv | 26 ++
 rtl/stream_fifo.sv | 60 ++++++
 rtl/usb_uart_msg_mux.sv | 165 ++++++++++++++++
 tb/tb_usb_uart_msg_mux.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_pkg.sv
// Shared types for the USB UART transmit-side glue.
// Holds the mux state enum, byte width and message byte selection.
package usb_uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int MSG_MAX   = 64;
  localparam int MSG_MAX_W = MSG_MAX * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    ECHO
  } state_e;

  // Byte idx of a packed len-byte message, first byte in the MSBs.
  function automatic logic [BYTE_W-1:0] msg_byte(
    input logic [MSG_MAX_W-1:0] msg,
    input int unsigned          len,
    input int unsigned          idx
  );
    logic [MSG_MAX_W-1:0] sh;
    sh = msg >> ((len - 1 - idx) * BYTE_W);
    return sh[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered occupancy, head visible on rdata_o.
// Ports: push/wdata in, pop in, rdata/full/empty/level out; sync active-low reset.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign level_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (PTR_W+1)'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/usb_uart_msg_mux.sv
// Merges a periodic fixed message and an rx echo FIFO onto the UART tx stream.
// Ports: rx valid/ready in, tx valid/ready out, busy, fifo_level, msg_count.
module usb_uart_msg_mux
  import usb_uart_pkg::*;
#(
  parameter int                   MSG_LEN    = 13,
  parameter logic [8*MSG_LEN-1:0] MSG        = 104'h68656c6c6f20776f726c640a0d,
  parameter int                   PERIOD     = 48000000,
  parameter int                   FIFO_DEPTH = 16
) (
  input  logic                        clk_48mhz,
  input  logic                        reset,
  input  logic                        msg_en,
  input  logic                        echo_en,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 msg_count
);

  localparam int IDX_W = $clog2(MSG_LEN + 1);
  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [MSG_MAX_W-1:0] MSG_EXT = MSG_MAX_W'(MSG);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [15:0]       count_q, count_d;

  logic              wrap;
  logic              xfer;
  logic              last;
  logic              start_msg;
  logic              start_echo;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  // With echo off, rx bytes are swallowed so the host never stalls.
  assign rx_ready  = echo_en ? !fifo_full : 1'b1;
  assign fifo_push = echo_en && rx_valid && !fifo_full;

  stream_fifo #(
    .WIDTH(BYTE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_echo_fifo (
    .clk_i  (clk_48mhz),
    .rst_ni (reset),
    .push_i (fifo_push),
    .wdata_i(rx_data),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign wrap       = cnt_q == CNT_W'(PERIOD - 1);
  assign xfer       = tx_valid_q && tx_ready;
  assign last       = idx_q == IDX_W'(MSG_LEN - 1);
  assign start_msg  = state_q == usb_uart_pkg::IDLE && pending_q;
  assign start_echo = state_q == usb_uart_pkg::IDLE && !pending_q &&
                      echo_en && !fifo_empty;

  // Trigger pending flag; a wrap on the start cycle re-arms it.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (!msg_en) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap)           pending_d = 1'b1;
      else if (start_msg) pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      state_q    <= usb_uart_pkg::IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      usb_uart_pkg::IDLE: begin
        if (start_msg)       state_d = usb_uart_pkg::MSG;
        else if (start_echo) state_d = usb_uart_pkg::ECHO;
      end
      usb_uart_pkg::MSG:  if (xfer && last) state_d = usb_uart_pkg::IDLE;
      usb_uart_pkg::ECHO: if (xfer)         state_d = usb_uart_pkg::IDLE;
      default:                              state_d = usb_uart_pkg::IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    count_d    = count_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      usb_uart_pkg::IDLE: begin
        if (start_msg) begin
          idx_d      = '0;
          tx_data_d  = msg_byte(MSG_EXT, MSG_LEN, 0);
          tx_valid_d = 1'b1;
        end else if (start_echo) begin
          tx_data_d  = fifo_head;
          tx_valid_d = 1'b1;
        end
      end
      usb_uart_pkg::MSG: begin
        if (xfer) begin
          if (last) begin
            tx_valid_d = 1'b0;
            count_d    = count_q + 16'd1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = msg_byte(MSG_EXT, MSG_LEN, 32'(idx_q) + 32'd1);
          end
        end
      end
      usb_uart_pkg::ECHO: begin
        if (xfer) begin
          fifo_pop   = 1'b1;
          tx_valid_d = 1'b0;
        end
      end
      default: tx_valid_d = 1'b0;
    endcase
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = state_q == usb_uart_pkg::MSG;
  assign msg_count = count_q;

endmodule

// File: tb/tb_usb_uart_msg_mux.sv
// Scoreboard bench for usb_uart_msg_mux with PERIOD=100.
// Stimulus queues expected tx bytes; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_usb_uart_msg_mux;

  localparam int MSG_LEN = 13;
  localparam int PERIOD  = 100;
  localparam int DEPTH   = 16;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       msg_en;
  logic       echo_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [4:0] fifo_level;
  logic [15:0] msg_count;

  logic [7:0] msg_bytes [MSG_LEN] = '{
    8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h77,
    8'h6f, 8'h72, 8'h6c, 8'h64, 8'h0a, 8'h0d
  };

  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         xfers = 0;
  int         busy_cycles = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;
  logic [7:0] e;
  int         cyc;
  int         base;

  usb_uart_msg_mux #(
    .MSG_LEN   (MSG_LEN),
    .MSG       (104'h68656c6c6f20776f726c640a0d),
    .PERIOD    (PERIOD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .msg_en    (msg_en),
    .echo_en   (echo_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .fifo_level(fifo_level),
    .msg_count (msg_count)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Monitor: a byte moves on the next posedge when valid && ready here.
  always @(negedge clk_48mhz) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (hold) begin
        n_cmp++;
        if (!tx_valid || tx_data !== hold_data) begin
          n_bad++;
          $display("FAIL hold: valid=%0b data=%02h, want valid=1 data=%02h",
                   tx_valid, tx_data, hold_data);
        end
      end
      if (tx_valid && tx_ready) begin
        xfers++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL xfer: unexpected byte %02h, want none", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_bad++;
            $display("FAIL xfer %0d: got %02h want %02h", xfers, tx_data, e);
          end
        end
      end
      hold      = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_msg(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(msg_bytes[i]);
  endtask

  task automatic wait_empty(input string name, input int bound,
                            input bit tog);
    int t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      step(1);
      if (tog) tx_ready = ~tx_ready;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout with %0d bytes left, want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_xfers(input string name, input int target,
                            input int bound);
    int t = 0;
    while (xfers < target && t < bound) begin
      step(1);
      t++;
    end
    if (xfers < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout at %0d transfers, want %0d",
               name, xfers, target);
    end
  endtask

  initial begin
    reset    = 1'b0;
    msg_en   = 1'b0;
    echo_en  = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    step(3);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_msg_count", msg_count, 0);
    chk("rst_fifo_level", fifo_level, 0);

    // Message with tx_ready held high; edge 0 is the first with reset high.
    msg_en = 1'b1;
    push_msg(MSG_LEN);
    reset = 1'b1;
    busy_cycles = 0;
    cyc = 0;
    step(1);
    while (!tx_valid && cyc < 300) begin
      step(1);
      cyc++;
    end
    chk("first_valid_cycle", cyc, 100);
    chk("first_byte", tx_data, 8'h68);
    wait_empty("msg1", 100, 1'b0);
    step(2);
    chk("msg1_count", msg_count, 1);
    chk("msg1_busy_cycles", busy_cycles, 13);
    chk("msg1_idle", tx_valid, 0);

    // Second message with tx_ready toggling every cycle.
    push_msg(MSG_LEN);
    wait_empty("msg2_toggle", 400, 1'b1);
    tx_ready = 1'b1;
    step(2);
    msg_en = 1'b0;
    chk("msg2_count", msg_count, 2);

    // Echo fill to full with the sink stalled, then drain.
    echo_en  = 1'b1;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      if (i == 15) chk("rx_ready_before_full", rx_ready, 1);
      exp_q.push_back(8'(i));
      step(1);
    end
    rx_data = 8'h10;
    chk("rx_ready_full", rx_ready, 0);
    chk("fifo_level_full", fifo_level, 16);
    step(3);
    chk("rx_ready_full_hold", rx_ready, 0);
    tx_ready = 1'b1;
    for (int i = 16; i < 20; i++) begin
      int t = 0;
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      exp_q.push_back(8'(i));
      while (!rx_ready && t < 50) begin
        step(1);
        t++;
      end
      chk("rx_ready_refill", rx_ready, 1);
      step(1);
    end
    rx_valid = 1'b0;
    wait_empty("echo_drain", 200, 1'b0);
    step(3);
    chk("echo_level_empty", fifo_level, 0);
    chk("echo_idle", tx_valid, 0);

    // With echo off, rx bytes are accepted and dropped.
    echo_en  = 1'b0;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    chk("discard_rx_ready", rx_ready, 1);
    step(2);
    rx_valid = 1'b0;
    chk("discard_level", fifo_level, 0);
    echo_en = 1'b1;
    step(5);
    chk("discard_no_echo", tx_valid, 0);

    // Trigger lands on the AA transfer edge: AA, message, then BB.
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    step(1);
    rx_data = 8'hBB;
    step(1);
    rx_valid = 1'b0;
    exp_q.push_back(8'hAA);
    push_msg(MSG_LEN);
    exp_q.push_back(8'hBB);
    msg_en = 1'b1;
    step(99);
    tx_ready = 1'b1;
    wait_empty("echo_msg_mix", 200, 1'b0);
    step(2);
    msg_en = 1'b0;
    chk("mix_count", msg_count, 3);
    chk("mix_level", fifo_level, 0);

    // Drop msg_en while byte 5 is presented.
    echo_en = 1'b0;
    msg_en  = 1'b1;
    push_msg(MSG_LEN);
    base = xfers;
    wait_xfers("msg_en_drop", base + 5, 300);
    msg_en = 1'b0;
    wait_empty("msg_en_drop_tail", 100, 1'b0);
    step(2);
    chk("drop_count", msg_count, 4);
    base = xfers;
    step(250);
    chk("drop_no_more", xfers, base);
    chk("drop_busy", busy, 0);

    // Reset while byte 7 is presented, with bytes parked in the FIFO.
    echo_en  = 1'b1;
    tx_ready = 1'b0;
    msg_en   = 1'b1;
    push_msg(7);
    cyc = 0;
    while (!busy && cyc < 200) begin
      step(1);
      cyc++;
    end
    chk("rst_test_busy", busy, 1);
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h31 + 8'(i);
      step(1);
    end
    rx_valid = 1'b0;
    chk("rst_test_level", fifo_level, 3);
    base = xfers;
    tx_ready = 1'b1;
    wait_xfers("rst_mid", base + 7, 50);
    reset = 1'b0;
    step(1);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_count", msg_count, 0);
    chk("midrst_busy", busy, 0);
    echo_en = 1'b0;
    push_msg(MSG_LEN);
    reset = 1'b1;
    wait_empty("restart_msg", 300, 1'b0);
    step(2);
    chk("restart_count", msg_count, 1);
    msg_en = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
